seq_mul_assign: RTL
===================

Name: seq_mul_assign

Overview:
- Parametrised multi-cycle multiplier modelling SystemVerilog `*=` compound-assignment semantics: full-width products and a truncating accumulator (`acc *= operand`), signed or unsigned per command.
- Iterative shift-add datapath with valid/ready handshakes on both sides.
- Serves as a sequential cosim target alongside the combinational compound-assignment tests in the same directory.

Parameters:
- W, 4, operand width in bits (>=2).
- ACCW, 8, accumulator width in bits (>=W).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  command valid.
- in_ready  output  1  block can accept a command.
- in_cmd  input  2  0=MUL, 1=ACC_MUL, 2=ACC_LOAD, 3=ACC_CLR.
- in_sgn  input  1  1=signed interpretation, 0=unsigned.
- in_a  input  W  operand A.
- in_b  input  W  operand B.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_prod  output  2W  MUL product (last MUL result, held otherwise).
- out_acc  output  ACCW  accumulator value.

Behaviour:
- Reset is asynchronous, active-low; the clock is single.
- On reset: state IDLE, in_ready=1, out_valid=0, out_prod=0, out_acc/acc=0, iteration counter=0.
- States:
  - IDLE: in_ready=1.
  - BUSY: in_ready=0.
  - DONE: out_valid=1, in_ready=0.
- in_ready is exactly (state==IDLE); there is no overlap between commands.
- Accept happens on an edge with in_valid&&in_ready; cmd, sgn, a and b are registered.
- MUL:
  - Signed: sign-magnitude. Magnitudes |a| and |b| are formed as W-bit unsigned values (the most negative value maps to 2^(W-1)), multiplied unsigned, and the 2W result is negated mod 2^2W if the signs differ.
  - Unsigned: plain W x W -> 2W product.
  - One multiplier bit per cycle, W iterations. The DONE state and out_prod are visible after the W-th edge following accept.
- ACC_MUL:
  - in_b is extended to ACCW bits: sign-extended if sgn=1, zero-extended if sgn=0.
  - acc = (acc * ext_b) mod 2^ACCW, i.e. the truncated product; low bits are identical for signed and unsigned.
  - ACCW iterations; acc and out_acc update and DONE is entered after the ACCW-th edge following accept.
  - out_prod is unchanged.
- ACC_LOAD: acc = ext(in_a) to ACCW bits, extended per sgn. DONE is entered on the accepting edge itself, so out_valid is visible in the next cycle.
- ACC_CLR: acc = 0. DONE is entered on the accepting edge itself.
- The accumulator is not modified while BUSY. The partial accumulator lives in a separate working register and is committed only on completion.
- DONE: outputs are held stable until out_valid&&out_ready. On that edge the state moves to IDLE; a new command cannot be accepted on the same edge.
- out_ready is ignored outside DONE. in_valid and operand inputs are ignored while BUSY or DONE.
- Reset asserted mid-operation aborts immediately: state goes to IDLE and all registers, including acc, are cleared.
- Widths: all internal arithmetic is done at 2W (MUL) or ACCW (ACC_MUL) bits, and no carry is kept beyond those widths.

Test Plan:
- W=4, ACCW=8, unsigned MUL a=0xF, b=0xF -> out_prod=0xE1, out_valid rises 4 cycles after accept, held while out_ready=0 for 3 cycles, then drops one cycle after out_ready=1.
- Signed MUL cases:
  - a=0xF, b=0xF -> 0x01.
  - a=0x8, b=0x8 -> 0x40.
  - a=0x7, b=0x8 -> 0xC8.
  - unsigned a=0x8, b=0x8 -> 0x40.
- Accumulator sequences:
  - signed ACC_LOAD a=0xC -> out_acc=0xFC after 1 cycle; then signed ACC_MUL b=0x3 -> out_acc=0xF4 after 8 cycles.
  - unsigned ACC_LOAD a=0xC -> 0x0C; then unsigned ACC_MUL b=0xF -> 0xB4.
- Handshake: in_valid held high across back-to-back commands -> in_ready=0 throughout BUSY/DONE. Each command is accepted exactly once, and the second is accepted no earlier than the edge after the first result handshake.
- Reset: rst_n pulsed low mid-ACC_MUL (iteration 3) with acc=0x0C -> asynchronously out_valid=0, out_acc=0, in_ready=1; no result is ever produced for the aborted command.
- ACC_CLR after a nonzero acc -> out_acc=0x00 one cycle after accept; out_prod retains its previous MUL value.

Source files
------------

// File: rtl/seq_mul_assign.sv
// seq_mul_assign: iterative shift-add multiplier with an ACCW-bit accumulator.
// MUL produces a full 2W product (sign-magnitude when signed); ACC_MUL performs
// a truncating acc *= ext(b); ACC_LOAD / ACC_CLR set the accumulator directly.
// One command at a time: IDLE accepts, BUSY iterates, DONE holds the result
// until the consumer takes it.
//
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | waiting for a command, in_ready=1
// S_BUSY | shift-add iterations running, one multiplier bit per cycle
// S_DONE | result presented with out_valid=1 until out_ready
module seq_mul_assign #(
  parameter int W    = 4,
  parameter int ACCW = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_cmd,
  input  logic              in_sgn,
  input  logic [W-1:0]      in_a,
  input  logic [W-1:0]      in_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2*W-1:0]    out_prod,
  output logic [ACCW-1:0]   out_acc
);

  localparam int PW = 2 * W;
  // Shared datapath is wide enough for either the full product or the accumulator.
  localparam int DW = (PW > ACCW) ? PW : ACCW;
  localparam int CW = $clog2(DW + 1);

  localparam logic [DW-1:0] MASK_P = DW'({PW{1'b1}});
  localparam logic [DW-1:0] MASK_A = DW'({ACCW{1'b1}});

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    CMD_MUL      = 2'd0,
    CMD_ACC_MUL  = 2'd1,
    CMD_ACC_LOAD = 2'd2,
    CMD_ACC_CLR  = 2'd3
  } cmd_e;

  state_e          state_q;
  cmd_e            cmd_q;
  logic            in_ready_q;
  logic            out_valid_q;
  logic [PW-1:0]   prod_q;
  logic [ACCW-1:0] acc_q;
  logic [DW-1:0]   work_q;
  logic [DW-1:0]   mcand_q;
  logic [DW-1:0]   mplier_q;
  logic            neg_q;
  logic [CW-1:0]   cnt_q;

  logic [W-1:0]    mag_a;
  logic [W-1:0]    mag_b;
  logic            neg_d;
  logic [ACCW-1:0] ext_a;
  logic [ACCW-1:0] ext_b;
  logic [DW-1:0]   mask;
  logic [DW-1:0]   work_d;
  logic [DW-1:0]   mcand_d;
  logic [PW-1:0]   prod_mag;
  logic [PW-1:0]   prod_d;
  logic [ACCW-1:0] acc_d;
  logic            last_iter;

  // Operand preparation at accept time: magnitudes for signed MUL, extension for acc ops.
  always_comb begin
    mag_a = (in_sgn && in_a[W-1]) ? -in_a : in_a;
    mag_b = (in_sgn && in_b[W-1]) ? -in_b : in_b;
    neg_d = in_sgn && (in_a[W-1] ^ in_b[W-1]);
    ext_a = ACCW'(in_a);
    ext_b = ACCW'(in_b);
    if (in_sgn && in_a[W-1]) begin
      ext_a = ext_a | ~ACCW'({W{1'b1}});
    end
    if (in_sgn && in_b[W-1]) begin
      ext_b = ext_b | ~ACCW'({W{1'b1}});
    end
  end

  // One shift-add step; bits above the active width are dropped every cycle so
  // no carry survives beyond 2W (MUL) or ACCW (ACC_MUL).
  always_comb begin
    mask      = (cmd_q == CMD_MUL) ? MASK_P : MASK_A;
    work_d    = (mplier_q[0] ? (work_q + mcand_q) : work_q) & mask;
    mcand_d   = (mcand_q << 1) & mask;
    prod_mag  = work_d[PW-1:0];
    prod_d    = neg_q ? -prod_mag : prod_mag;
    acc_d     = work_d[ACCW-1:0];
    last_iter = (cnt_q == CW'(1));
  end

  // Control FSM and all datapath registers; outputs are registered here too.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cmd_q       <= CMD_MUL;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      prod_q      <= '0;
      acc_q       <= '0;
      work_q      <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      neg_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            cmd_q      <= cmd_e'(in_cmd);
            work_q     <= '0;
            in_ready_q <= 1'b0;
            case (cmd_e'(in_cmd))
              CMD_MUL: begin
                mcand_q  <= DW'(mag_a);
                mplier_q <= DW'(mag_b);
                neg_q    <= neg_d;
                cnt_q    <= CW'(W);
                state_q  <= S_BUSY;
              end
              CMD_ACC_MUL: begin
                // Current acc is snapshotted as the multiplicand; acc itself
                // stays untouched until the last iteration commits.
                mcand_q  <= DW'(acc_q);
                mplier_q <= DW'(ext_b);
                neg_q    <= 1'b0;
                cnt_q    <= CW'(ACCW);
                state_q  <= S_BUSY;
              end
              CMD_ACC_LOAD: begin
                acc_q       <= ext_a;
                out_valid_q <= 1'b1;
                state_q     <= S_DONE;
              end
              default: begin
                acc_q       <= '0;
                out_valid_q <= 1'b1;
                state_q     <= S_DONE;
              end
            endcase
          end
        end
        S_BUSY: begin
          work_q   <= work_d;
          mcand_q  <= mcand_d;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q - CW'(1);
          if (last_iter) begin
            if (cmd_q == CMD_MUL) begin
              prod_q <= prod_d;
            end else begin
              acc_q <= acc_d;
            end
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end
        end
        S_DONE: begin
          // Return to IDLE only; a new command waits for the following edge.
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_prod  = prod_q;
  assign out_acc   = acc_q;

endmodule
